mem_arbiter: RTL and testbench

Sequences and shares the single-ported, pipelined main memory between the I-cache and D-cache miss handlers of the 5-stage pipeline. It grants one requester at a time and issues the 8 word reads of a block fill back-to-back. It steers returning data into the granted cache with a word index, and issues D-cache write-through stores. The hazard/stall logic consumes `busy` and the per-cache `done` pulses to freeze IF or MEM while a miss is serviced.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_fill_counter.sv | 40 ++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths, timing constants and state codes for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned MEM_LAT     = 4;
  localparam int unsigned WORD_IDX_W  = $clog2(BLOCK_WORDS);
  localparam int unsigned BLK_OFF_W   = WORD_IDX_W + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_D_FILL  = 2'd1;
  localparam logic [1:0] ST_I_FILL  = 2'd2;
  localparam logic [1:0] ST_D_WRITE = 2'd3;

  function automatic logic [WORD_IDX_W-1:0] next_word(input logic [WORD_IDX_W-1:0] w);
    return w + WORD_IDX_W'(1);
  endfunction

endpackage

// File: rtl/mem_fill_counter.sv
// Issue and receive word counters for a block fill, shared by both fill states.
module mem_fill_counter
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  issue_en,
  input  logic                  rx_en,
  output logic [WORD_IDX_W-1:0] issue_idx,
  output logic [WORD_IDX_W-1:0] rx_idx,
  output logic                  issuing,
  output logic                  rx_last
);

  logic issue_last;

  assign issue_last = (issue_idx == WORD_IDX_W'(BLOCK_WORDS - 1));
  assign rx_last    = (rx_idx == WORD_IDX_W'(BLOCK_WORDS - 1));

  // Both counters wrap back to zero after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_idx <= '0;
      rx_idx    <= '0;
      issuing   <= 1'b0;
    end else if (clr) begin
      issue_idx <= '0;
      rx_idx    <= '0;
      issuing   <= 1'b1;
    end else begin
      if (issue_en && issuing) begin
        issue_idx <= next_word(issue_idx);
        if (issue_last) issuing <= 1'b0;
      end
      if (rx_en) rx_idx <= next_word(rx_idx);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported pipelined main memory between I-cache and D-cache
// miss handlers: block fills, D write-through stores, and fill data steering.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_fill_we,
  output logic [WORD_IDX_W-1:0] i_fill_word,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_fill_we,
  output logic [WORD_IDX_W-1:0] d_fill_word,
  output logic                  d_done,
  output logic [DATA_W-1:0]     fill_data,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  busy
);

  logic [1:0]              state, state_nxt;
  logic                    last_was_dfill;
  logic [ADDR_W-2:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    grant_d, grant_i;
  logic                    in_fill, rx_en, fill_last_rx;
  logic [WORD_IDX_W-1:0]   issue_idx, rx_idx;
  logic                    issuing, rx_last;
  logic [ADDR_W-1:0]       fill_addr;
  logic                    unused_addr_lsb;

  // Byte-lane bit of both request addresses is meaningless for 16-bit words.
  assign unused_addr_lsb = i_addr[0] ^ d_addr[0];

  assign in_fill      = (state == ST_D_FILL) || (state == ST_I_FILL);
  assign rx_en        = in_fill && mem_rvalid;
  assign fill_last_rx = rx_en && rx_last;
  assign fill_addr    = {addr_q[ADDR_W-2:BLK_OFF_W-1], issue_idx, 1'b0};
  assign fill_data    = mem_rdata;

  mem_fill_counter u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (grant_d | grant_i),
    .issue_en  (in_fill),
    .rx_en     (rx_en),
    .issue_idx (issue_idx),
    .rx_idx    (rx_idx),
    .issuing   (issuing),
    .rx_last   (rx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Grant capture and fairness flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      last_was_dfill <= 1'b0;
    end else begin
      if (grant_d) begin
        addr_q  <= d_addr[ADDR_W-1:1];
        wdata_q <= d_wdata;
      end else if (grant_i) begin
        addr_q  <= i_addr[ADDR_W-1:1];
      end
      if (fill_last_rx) last_was_dfill <= (state == ST_D_FILL);
    end
  end

  // Arbitration, sequencing and output decode.
  always_comb begin
    state_nxt   = state;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    busy        = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_fill_we   = 1'b0;
    i_fill_word = '0;
    i_done      = 1'b0;
    d_fill_we   = 1'b0;
    d_fill_word = '0;
    d_done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (d_req && (!last_was_dfill || !i_req)) begin
          grant_d   = 1'b1;
          state_nxt = d_wr ? ST_D_WRITE : ST_D_FILL;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nxt = ST_I_FILL;
        end
      end
      ST_D_FILL: begin
        busy        = 1'b1;
        mem_en      = issuing;
        mem_addr    = issuing ? fill_addr : '0;
        d_fill_we   = mem_rvalid;
        d_fill_word = rx_idx;
        d_done      = fill_last_rx;
        if (fill_last_rx) state_nxt = ST_IDLE;
      end
      ST_I_FILL: begin
        busy        = 1'b1;
        mem_en      = issuing;
        mem_addr    = issuing ? fill_addr : '0;
        i_fill_we   = mem_rvalid;
        i_fill_word = rx_idx;
        i_done      = fill_last_rx;
        if (fill_last_rx) state_nxt = ST_IDLE;
      end
      ST_D_WRITE: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {addr_q, 1'b0};
        mem_wdata = wdata_q;
        d_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-schedule reference model and a fixed-latency memory responder.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int BW = BLOCK_WORDS;
  localparam int L  = MEM_LAT;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  i_req, d_req, d_wr;
  logic [15:0]           i_addr, d_addr, d_wdata;
  logic                  i_fill_we, i_done, d_fill_we, d_done;
  logic [WORD_IDX_W-1:0] i_fill_word, d_fill_word;
  logic [15:0]           fill_data, mem_addr, mem_wdata, mem_rdata;
  logic                  mem_en, mem_wr, mem_rvalid, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int due; logic [15:0] addr; } rd_t;
  rd_t rq[$];

  // Reference model: owner 0 none, 1 I fill, 2 D fill, 3 D write; g = grant cycle.
  int          m_own, m_g;
  logic [15:0] m_addr, m_wd;
  bit          m_last_d;
  logic        e_busy, e_en, e_wr, e_iwe, e_idone, e_dwe, e_ddone;
  logic [15:0] e_addr, e_wd, e_data;
  logic [WORD_IDX_W-1:0] e_iword, e_dword;

  mem_arbiter #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_fill_we(i_fill_we), .i_fill_word(i_fill_word), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_fill_we(d_fill_we), .d_fill_word(d_fill_word), .d_done(d_done),
    .fill_data(fill_data), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return 16'(a * 16'd37) ^ 16'h5A3C;
  endfunction

  // One cycle: memory responds just after the edge, outputs sampled mid-cycle.
  task automatic step();
    rd_t r;
    @(posedge clk);
    #1;
    cyc++;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    while (rq.size() > 0 && rq[0].due < cyc) r = rq.pop_front();
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = mem_val(r.addr);
    end
    @(negedge clk);
    if (mem_en && !mem_wr) begin
      r.due  = cyc + L;
      r.addr = mem_addr;
      rq.push_back(r);
    end
  endtask

  task automatic model_out(input int c);
    int rel;
    logic [15:0] base;
    rel  = c - m_g;
    base = {m_addr[15:4], 4'h0};
    {e_busy, e_en, e_wr, e_iwe, e_idone, e_dwe, e_ddone} = '0;
    e_addr = '0; e_wd = '0; e_data = '0; e_iword = '0; e_dword = '0;
    if (m_own == 1 || m_own == 2) begin
      e_busy = 1'b1;
      if (rel >= 1 && rel <= BW) begin
        e_en   = 1'b1;
        e_addr = base + 16'(2 * (rel - 1));
      end
      if (rel >= 1 + L && rel <= BW + L) begin
        e_data = mem_val(base + 16'(2 * (rel - 1 - L)));
        if (m_own == 1) begin e_iwe = 1'b1; e_iword = WORD_IDX_W'(rel - 1 - L); end
        else begin e_dwe = 1'b1; e_dword = WORD_IDX_W'(rel - 1 - L); end
      end
      if (rel == BW + L) begin
        if (m_own == 1) e_idone = 1'b1;
        else e_ddone = 1'b1;
      end
    end else if (m_own == 3) begin
      e_busy = 1'b1; e_en = 1'b1; e_wr = 1'b1; e_ddone = 1'b1;
      e_addr = {m_addr[15:1], 1'b0};
      e_wd   = m_wd;
    end
  endtask

  // Advance the model across the edge that ends cycle c, using the inputs now driven.
  task automatic model_edge(input int c);
    bit was_idle;
    was_idle = (m_own == 0);
    if ((m_own == 1 || m_own == 2) && (c - m_g) == BW + L) begin
      m_last_d = (m_own == 2);
      m_own    = 0;
    end
    if (m_own == 3 && (c - m_g) == 1) m_own = 0;
    if (was_idle) begin
      if (d_req && (!m_last_d || !i_req)) begin
        m_own = d_wr ? 3 : 2; m_addr = d_addr; m_wd = d_wdata; m_g = c;
      end else if (i_req) begin
        m_own = 1; m_addr = i_addr; m_g = c;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_req = 0; d_req = 0; d_wr = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_rvalid = 1'b1; mem_rdata = 16'hA1B2;
    #3;
    checks++; if ({busy, mem_en, mem_wr, mem_addr, mem_wdata} !== '0) begin failures++;
      $display("FAIL reset_mem got=%h exp=0", {busy, mem_en, mem_wr, mem_addr, mem_wdata}); end
    checks++; if ({i_fill_we, i_fill_word, i_done, d_fill_we, d_fill_word, d_done} !== '0) begin failures++;
      $display("FAIL reset_fill got=%h exp=0", {i_fill_we, i_fill_word, i_done, d_fill_we, d_fill_word, d_done}); end
    checks++; if (fill_data !== 16'hA1B2) begin failures++;
      $display("FAIL reset_fill_data got=%h exp=a1b2", fill_data); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if ({busy, mem_en, i_fill_we, d_fill_we} !== 4'b0) begin failures++;
      $display("FAIL post_reset_idle got=%b exp=0000", {busy, mem_en, i_fill_we, d_fill_we}); end
  endtask

  task automatic test_i_fill();
    step();
    i_addr = 16'h1236; i_req = 1'b1;
    for (int r = 1; r <= 14; r++) begin
      step();
      checks++; if (mem_en !== (r >= 1 && r <= BW)) begin failures++;
        $display("FAIL ifill_mem_en r=%0d got=%b", r, mem_en); end
      if (r >= 1 && r <= BW) begin
        checks++; if (mem_addr !== 16'h1230 + 16'(2 * (r - 1))) begin failures++;
          $display("FAIL ifill_addr r=%0d got=%h exp=%h", r, mem_addr, 16'h1230 + 16'(2 * (r - 1))); end
      end
      checks++; if (i_fill_we !== (r >= 1 + L && r <= BW + L)) begin failures++;
        $display("FAIL ifill_we r=%0d got=%b", r, i_fill_we); end
      if (r >= 1 + L && r <= BW + L) begin
        checks++; if (i_fill_word !== WORD_IDX_W'(r - 1 - L) || fill_data !== mem_val(16'h1230 + 16'(2 * (r - 1 - L)))) begin
          failures++; $display("FAIL ifill_word r=%0d got=%0d/%h", r, i_fill_word, fill_data); end
      end
      checks++; if (i_done !== (r == BW + L) || busy !== (r <= BW + L)) begin failures++;
        $display("FAIL ifill_done_busy r=%0d got=%b%b", r, i_done, busy); end
      checks++; if ({d_fill_we, d_fill_word, d_done} !== '0) begin failures++;
        $display("FAIL ifill_d_quiet r=%0d got=%h exp=0", r, {d_fill_we, d_fill_word, d_done}); end
      if (i_done) i_req = 1'b0;
    end
  endtask

  task automatic test_both_fill();
    bit exp_en;
    step();
    d_addr = 16'h2000; d_wr = 1'b0; d_req = 1'b1;
    i_addr = 16'h3010; i_req = 1'b1;
    for (int r = 1; r <= 27; r++) begin
      step();
      exp_en = (r >= 1 && r <= 8) || (r >= 14 && r <= 21);
      checks++; if (mem_en !== exp_en) begin failures++;
        $display("FAIL both_mem_en r=%0d got=%b exp=%b", r, mem_en, exp_en); end
      if (exp_en) begin
        checks++; if (mem_addr !== ((r <= 8) ? 16'h2000 + 16'(2 * (r - 1)) : 16'h3010 + 16'(2 * (r - 14)))) begin
          failures++; $display("FAIL both_addr r=%0d got=%h", r, mem_addr); end
      end
      checks++; if (d_fill_we !== (r >= 5 && r <= 12) || d_done !== (r == 12)) begin failures++;
        $display("FAIL both_d r=%0d got we=%b done=%b", r, d_fill_we, d_done); end
      checks++; if (i_fill_we !== (r >= 18 && r <= 25) || i_done !== (r == 25)) begin failures++;
        $display("FAIL both_i r=%0d got we=%b done=%b", r, i_fill_we, i_done); end
      checks++; if (busy !== ((r >= 1 && r <= 12) || (r >= 14 && r <= 25))) begin failures++;
        $display("FAIL both_busy r=%0d got=%b", r, busy); end
      if (d_done) d_req = 1'b0;
      if (i_done) i_req = 1'b0;
    end
  endtask

  task automatic test_d_write();
    step();
    d_addr = 16'h4003; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
    step();
    checks++; if ({mem_en, mem_wr, d_done, busy} !== 4'b1111) begin failures++;
      $display("FAIL dwr_strobes got=%b exp=1111", {mem_en, mem_wr, d_done, busy}); end
    checks++; if (mem_addr !== 16'h4002 || mem_wdata !== 16'hBEEF) begin failures++;
      $display("FAIL dwr_addr_data got=%h/%h exp=4002/beef", mem_addr, mem_wdata); end
    d_req = 1'b0; d_wr = 1'b0;
    step();
    checks++; if ({busy, mem_en, d_done} !== 3'b000) begin failures++;
      $display("FAIL dwr_idle got=%b exp=000", {busy, mem_en, d_done}); end
  endtask

  task automatic test_reset_mid_fill();
    step();
    i_addr = 16'h7770; i_req = 1'b1;
    for (int r = 1; r <= 7; r++) step();
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, mem_en, mem_wr, mem_addr, mem_wdata, i_fill_we, i_fill_word, i_done} !== '0) begin failures++;
      $display("FAIL midrst_outputs got=%h exp=0", {busy, mem_en, mem_wr, mem_addr, mem_wdata, i_fill_we, i_fill_word, i_done}); end
    i_req = 1'b0;
    for (int r = 8; r <= 16; r++) begin
      step();
      if (r == 8) rst_n = 1'b1;
      checks++; if ({i_fill_we, i_done, d_fill_we, busy, mem_en} !== 5'b0) begin failures++;
        $display("FAIL midrst_stale r=%0d got=%b exp=00000", r, {i_fill_we, i_done, d_fill_we, busy, mem_en}); end
    end
    step();
    i_addr = 16'h0840; i_req = 1'b1;
    for (int r = 1; r <= 13; r++) begin
      step();
      checks++; if (i_fill_we !== (r >= 1 + L && r <= BW + L) || i_done !== (r == BW + L)) begin failures++;
        $display("FAIL midrst_refill r=%0d got we=%b done=%b", r, i_fill_we, i_done); end
      if (r >= 1 + L && r <= BW + L) begin
        checks++; if (fill_data !== mem_val(16'h0840 + 16'(2 * (r - 1 - L))) || i_fill_word !== WORD_IDX_W'(r - 1 - L)) begin
          failures++; $display("FAIL midrst_refill_data r=%0d got=%h/%0d", r, fill_data, i_fill_word); end
      end
      if (i_done) i_req = 1'b0;
    end
  endtask

  task automatic test_addr_change();
    int issues;
    issues = 0;
    step();
    i_addr = 16'h5A4C; i_req = 1'b1;
    for (int r = 1; r <= 13; r++) begin
      step();
      i_addr = 16'($urandom);
      if (mem_en) begin
        checks++; if (mem_addr !== 16'h5A40 + 16'(2 * issues)) begin failures++;
          $display("FAIL addrchg_addr r=%0d got=%h exp=%h", r, mem_addr, 16'h5A40 + 16'(2 * issues)); end
        issues++;
      end
      if (i_done) i_req = 1'b0;
    end
    checks++; if (issues != BW) begin failures++;
      $display("FAIL addrchg_issue_count got=%0d exp=%0d", issues, BW); end
  endtask

  task automatic test_alternation();
    int lat, dd;
    bit got;
    step();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom);
    for (int round = 0; round < 4; round++) begin
      repeat ($urandom_range(12, 1)) begin
        step();
        if (d_done) d_addr = 16'($urandom);
      end
      i_req = 1'b1; i_addr = 16'($urandom);
      lat = 0; dd = 0; got = 1'b0;
      while (!got && lat < 60) begin
        step();
        lat++;
        if (d_done) begin dd++; d_addr = 16'($urandom); end
        if (i_done) got = 1'b1;
      end
      i_req = 1'b0;
      checks++; if (!got || lat > 26) begin failures++;
        $display("FAIL alt_i_latency round=%0d got=%0d exp<=26", round, lat); end
      checks++; if (dd > 1) begin failures++;
        $display("FAIL alt_d_between round=%0d got=%0d exp<=1", round, dd); end
    end
    for (int k = 0; k < 30 && d_req; k++) begin
      step();
      if (d_done) d_req = 1'b0;
    end
    d_req = 1'b0;
  endtask

  task automatic test_random();
    @(negedge clk);
    rst_n = 1'b0; i_req = 0; d_req = 0; d_wr = 0;
    step();
    rst_n = 1'b1;
    repeat (12) step();
    m_own = 0; m_g = 0; m_last_d = 0; m_addr = '0; m_wd = '0;
    for (int k = 0; k < 1500; k++) begin
      step();
      model_out(cyc);
      checks++; if ({busy, mem_en, mem_wr} !== {e_busy, e_en, e_wr}) begin failures++;
        $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, {busy, mem_en, mem_wr}, {e_busy, e_en, e_wr}); end
      if (e_en) begin
        checks++; if (mem_addr !== e_addr) begin failures++;
          $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, e_addr); end
      end
      if (e_wr) begin
        checks++; if (mem_wdata !== e_wd) begin failures++;
          $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, e_wd); end
      end
      checks++; if ({i_fill_we, i_done, d_fill_we, d_done} !== {e_iwe, e_idone, e_dwe, e_ddone}) begin failures++;
        $display("FAIL rnd_fill cyc=%0d got=%b exp=%b", cyc, {i_fill_we, i_done, d_fill_we, d_done}, {e_iwe, e_idone, e_dwe, e_ddone}); end
      if (e_iwe || e_dwe) begin
        checks++; if (fill_data !== e_data || (e_iwe && i_fill_word !== e_iword) || (e_dwe && d_fill_word !== e_dword)) begin
          failures++; $display("FAIL rnd_data cyc=%0d got=%h/%0d/%0d exp=%h/%0d/%0d", cyc, fill_data, i_fill_word, d_fill_word, e_data, e_iword, e_dword); end
      end
      checks++; if ((m_own != 1 && i_fill_word !== '0) || (m_own == 1 && d_fill_word !== '0)) begin failures++;
        $display("FAIL rnd_ungranted_word cyc=%0d got=%0d/%0d exp=0", cyc, i_fill_word, d_fill_word); end
      if (i_req && e_idone) i_req = 1'b0;
      else if (!i_req && $urandom_range(3) == 0) begin i_req = 1'b1; i_addr = 16'($urandom); end
      else if (i_req && $urandom_range(3) == 0) i_addr = 16'($urandom);
      if (d_req && e_ddone) d_req = 1'b0;
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_wr = ($urandom_range(2) == 0);
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      model_edge(cyc);
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_both_fill();
    test_d_write();
    test_reset_mid_fill();
    test_addr_change();
    test_alternation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
